// File: rtl/compressor_4_2_pipe.sv
// rtl/compressor_4_2_pipe.sv - registered 4:2 carry-save compressor with valid/ready handshake
// Optional multi-beat accumulation is built when COMPRESSOR_ACCUM_EN is defined.
module compressor_4_2_pipe #(
    parameter  int WIDTH    = 24,
    parameter  int ACC_BITS = 4,
    localparam int OW       = WIDTH + 2,
    localparam int AW       = OW + ACC_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    output logic [AW-1:0]    sum_o,
    output logic [AW-1:0]    carry_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             acc_ovf
);

    // Returns {cout, carry, sum}; cout never depends on cin, sum is three XOR levels deep.
    function automatic logic [2:0] cell_4_2(input logic x1, input logic x2, input logic x3,
                                            input logic x4, input logic cin);
        logic p12, p34, p;
        p12 = x1 ^ x2;
        p34 = x3 ^ x4;
        p   = p12 ^ p34;
        return {(p12 ? x3 : x1), (p ? cin : x4), p ^ cin};
    endfunction

    logic [OW-1:0] sa, ca;
    logic [AW-1:0] sa_ext, ca_ext;
    logic          fire;

    always_comb begin : row_a
        logic [WIDTH:0] a1, a2, a3, a4;
        logic           c;
        logic [2:0]     r;
        a1 = {1'b0, in1};
        a2 = {1'b0, in2};
        a3 = {1'b0, in3};
        a4 = {1'b0, in4};
        sa = '0;
        ca = '0;
        c  = 1'b0;
        r  = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            r       = cell_4_2(a1[i], a2[i], a3[i], a4[i], c);
            sa[i]   = r[0];
            ca[i+1] = r[1];
            c       = r[2];
        end
    end

    assign sa_ext   = {{ACC_BITS{1'b0}}, sa};
    assign ca_ext   = {{ACC_BITS{1'b0}}, ca};
    assign in_ready = ~out_valid | out_ready;
    assign fire     = in_valid & in_ready;

`ifdef COMPRESSOR_ACCUM_EN
    localparam logic [0:0]          IDLE    = 1'b0;
    localparam logic [0:0]          ACC     = 1'b1;
    localparam logic [ACC_BITS-1:0] CNT_MAX = '1;

    logic [0:0]          state;
    logic [AW-1:0]       acc_s, acc_c, acc_s_eff, acc_c_eff;
    logic [AW-1:0]       rb_s, rb_c;
    logic [ACC_BITS-1:0] beat_cnt;
    logic                ovf_q;

    assign acc_s_eff = (state == ACC) ? acc_s : '0;
    assign acc_c_eff = (state == ACC) ? acc_c : '0;

    // Top-cell carries fall off the end: the accumulator is modulo 2^AW.
    always_comb begin : row_b
        logic       c;
        logic [2:0] r;
        rb_s = '0;
        rb_c = '0;
        c    = 1'b0;
        r    = '0;
        for (int i = 0; i < AW - 1; i++) begin
            r         = cell_4_2(sa_ext[i], ca_ext[i], acc_s_eff[i], acc_c_eff[i], c);
            rb_s[i]   = r[0];
            rb_c[i+1] = r[1];
            c         = r[2];
        end
        r          = cell_4_2(sa_ext[AW-1], ca_ext[AW-1], acc_s_eff[AW-1], acc_c_eff[AW-1], c);
        rb_s[AW-1] = r[0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_s     <= '0;
            acc_c     <= '0;
            beat_cnt  <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            sum_o     <= '0;
            carry_o   <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (fire) begin
                if (in_last) begin
                    sum_o     <= rb_s;
                    carry_o   <= rb_c;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                    acc_s     <= '0;
                    acc_c     <= '0;
                    beat_cnt  <= '0;
                end else begin
                    acc_s <= rb_s;
                    acc_c <= rb_c;
                    state <= ACC;
                    if (beat_cnt == CNT_MAX) begin
                        ovf_q <= 1'b1;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign acc_ovf = ovf_q;
`else
    logic unused_last;
    assign unused_last = in_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum_o     <= '0;
            carry_o   <= '0;
        end else if (fire) begin
            sum_o     <= sa_ext;
            carry_o   <= ca_ext;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign acc_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_compressor_4_2_pipe.sv
// tb/tb_compressor_4_2_pipe.sv - scoreboard bench for compressor_4_2_pipe (WIDTH=8, ACC_BITS=2)
module tb_compressor_4_2_pipe;
    localparam int WIDTH    = 8;
    localparam int ACC_BITS = 2;
    localparam int AW       = WIDTH + 2 + ACC_BITS;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in1, in2, in3, in4;
    logic             in_valid, in_ready, in_last;
    logic [AW-1:0]    sum_o, carry_o;
    logic             out_valid, out_ready, acc_ovf;
    logic [AW-1:0]    tot;

    int exp_q[$];
    int n_tests  = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    int n_pushed = 0;

    compressor_4_2_pipe #(.WIDTH(WIDTH), .ACC_BITS(ACC_BITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .sum_o(sum_o), .carry_o(carry_o),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_ovf(acc_ovf)
    );

    always #5 clk = ~clk;
    assign tot = sum_o + carry_o;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_result(input int v);
        exp_q.push_back(v);
        n_pushed++;
    endtask

    // Drive one beat from posedge+1 and return at posedge+1 after it transferred.
    task automatic beat(input int a, input int b, input int c, input int d, input bit last);
        int waited;
        in1 = a[WIDTH-1:0];
        in2 = b[WIDTH-1:0];
        in3 = c[WIDTH-1:0];
        in4 = d[WIDTH-1:0];
        in_last  = last;
        in_valid = 1'b1;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 20) begin
                check("beat_accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                check("unexpected_result", int'(tot), -1);
            end else begin
                check("result_total", int'(tot), exp_q.pop_front());
                check("carry_lsb", int'(carry_o[0]), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in1 = '0; in2 = '0; in3 = '0; in4 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_sum", int'(sum_o), 0);
        check("reset_carry", int'(carry_o), 0);
        check("reset_acc_ovf", int'(acc_ovf), 0);
        rst_n = 1'b1;
        tick();
        check("post_reset_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;

        // Idle cycles with junk on the operands must produce nothing.
        in1 = 8'hA5; in2 = 8'h3C; in3 = 8'hFF; in4 = 8'h01; in_last = 1'b1;
        repeat (4) tick();
        check("idle_no_output", int'(out_valid), 0);

        // All-ones operands, latency 1.
        expect_result(1020);
        beat(255, 255, 255, 255, 1'b1);
        check("latency1_valid", int'(out_valid), 1);
        tick();
        check("single_cleared", int'(out_valid), 0);

        // Three back-to-back beats.
        expect_result(10);
        expect_result(40);
        expect_result(256);
        beat(1, 2, 3, 4, 1'b1);
        check("b2b_valid_0", int'(out_valid), 1);
        beat(10, 10, 10, 10, 1'b1);
        check("b2b_valid_1", int'(out_valid), 1);
        beat(255, 0, 0, 1, 1'b1);
        check("b2b_valid_2", int'(out_valid), 1);
        tick();
        check("b2b_drained", int'(out_valid), 0);

        // Stall for five cycles, then release.
        out_ready = 1'b0;
        expect_result(18);
        beat(3, 4, 5, 6, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_valid", int'(out_valid), 1);
            check("stall_total", int'(tot), 18);
        end
        tick();
        out_ready = 1'b1;
        tick();
        check("stall_released", int'(out_valid), 0);

`ifdef COMPRESSOR_ACCUM_EN
        // Three-beat accumulation.
        expect_result(306);
        beat(1, 2, 3, 4, 1'b0);
        check("acc_nolast_valid_0", int'(out_valid), 0);
        beat(10, 10, 10, 10, 1'b0);
        check("acc_nolast_valid_1", int'(out_valid), 0);
        beat(255, 0, 0, 1, 1'b1);
        check("acc_last_valid", int'(out_valid), 1);
        tick();

        // Accumulator must be back to empty.
        expect_result(20);
        beat(5, 5, 5, 5, 1'b1);
        tick();

        // Beat-count overflow with ACC_BITS=2.
        for (int k = 0; k < 5; k++) begin
            beat(1, 1, 1, 1, 1'b0);
            if (k == 2) check("ovf_not_yet", int'(acc_ovf), 0);
        end
        check("ovf_set", int'(acc_ovf), 1);
        expect_result(20);
        beat(0, 0, 0, 0, 1'b1);
        check("ovf_sticky", int'(acc_ovf), 1);
        tick();
        rst_n = 1'b0;
        tick();
        check("ovf_reset", int'(acc_ovf), 0);
        check("reset_mid_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        tick();

        // Reset mid-accumulation discards the partial sum.
        beat(7, 7, 7, 7, 1'b0);
        beat(7, 7, 7, 7, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_result(20);
        beat(5, 5, 5, 5, 1'b1);
        tick();
`else
        // in_last is ignored: a non-last beat still produces a result.
        expect_result(30);
        beat(9, 8, 7, 6, 1'b0);
        check("nolast_valid", int'(out_valid), 1);
        tick();
        check("acc_ovf_tied", int'(acc_ovf), 0);
`endif

        repeat (3) tick();
        check("pending_results", exp_q.size(), 0);
        check("transfer_count", n_xfer, n_pushed);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
